// File: rtl/sw_debounce_pkg.sv
// Shared constants, edge encoding and counter sizing for the slide-switch debouncer.
// Used by sw_debounce and debounce_bit; see sw_debounce.sv for the SW_SYNC3_EN option.
package sw_debounce_pkg;

    localparam int SW_WIDTH                = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int BENCH_DEBOUNCE_CYCLES   = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // A single-cycle debounce still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: stability counter, debounced level and registered rise/fall pulses.
// The input must already be synchronized to clk.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          stable_next;
    edge_e         edge_next;

    // Any sample that agrees with the stable level wipes the run, so only an
    // uninterrupted run of mismatches reaching CNT_LAST flips the level.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable;
        edge_next   = EDGE_NONE;
        if (sync_in != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = sync_in;
                edge_next   = sync_in ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            stable <= stable_next;
            rise   <= (edge_next == EDGE_RISE);
            fall   <= (edge_next == EDGE_FALL);
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: synchronizer chain plus one debounce_bit per switch.
// Define SW_SYNC3_EN for a three-flop synchronizer (one extra cycle of latency).
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

`ifdef SW_SYNC3_EN
    logic [WIDTH-1:0] sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync3 <= '0;
        end else begin
            sync3 <= sync2;
        end
    end

    assign sync_out = sync3;
`else
    assign sync_out = sync2;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .sync_in(sync_out[i]),
            .stable (sw_stable[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    // Pulses are already registered, so the OR lines up with them in the same cycle.
    assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES overridden to the bench value.
// Expected latency follows SW_SYNC3_EN so the same vectors serve both builds.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W = SW_WIDTH;
    localparam int N = BENCH_DEBOUNCE_CYCLES;
`ifdef SW_SYNC3_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] value);
        sw_raw = value;
    endtask

    // Outputs are looked at 1ns after the rising edge they came from.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOutputs(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                                 input logic [W-1:0] fa, input logic ch);
        checkOutput({tag, ".stable"},  8'(sw_stable),  8'(st));
        checkOutput({tag, ".rise"},    8'(sw_rise),    8'(ri));
        checkOutput({tag, ".fall"},    8'(sw_fall),    8'(fa));
        checkOutput({tag, ".changed"}, 8'(sw_changed), 8'(ch));
    endtask

    // Raw change applied just after an edge is first sampled on the next edge (k);
    // the new level must appear exactly LAT edges later, with pulses for one cycle only.
    task automatic runTransition(input string tag, input logic [W-1:0] raw, input logic [W-1:0] oldSt,
                                 input logic [W-1:0] newSt, input logic [W-1:0] ri, input logic [W-1:0] fa);
        applyStimulus(raw);
        for (int s = 0; s < LAT; s++) begin
            step();
            expectOutputs({tag, ".wait"}, oldSt, '0, '0, 1'b0);
        end
        step();
        expectOutputs({tag, ".flip"}, newSt, ri, fa, 1'b1);
        step();
        expectOutputs({tag, ".after"}, newSt, '0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] bounce [5];
        bounce[0] = 4'b0000;
        bounce[1] = 4'b0001;
        bounce[2] = 4'b0000;
        bounce[3] = 4'b0001;
        bounce[4] = 4'b0000;

        rst = 1'b1;
        applyStimulus(4'b0000);
        step();
        expectOutputs("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step();
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            step();
            expectOutputs("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        runTransition("rise0",  4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        runTransition("fall0",  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        for (int b = 0; b < 5; b++) begin
            applyStimulus(bounce[b]);
            step();
            expectOutputs("bounce", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        for (int b = 0; b < LAT; b++) begin
            step();
            expectOutputs("bounce_drain", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        runTransition("bounce_hold", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        runTransition("clear1",      4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        runTransition("all_on",  4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        runTransition("to_1010", 4'b1010, 4'b1111, 4'b1010, 4'b0000, 4'b0101);

        // Bit 0 gets two counts in, then reset lands mid-cycle and must clear everything at once.
        applyStimulus(4'b1011);
        for (int s = 0; s < LAT - 1; s++) begin
            step();
            expectOutputs("pre_rst", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end
        #3;
        rst = 1'b1;
        #1;
        expectOutputs("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step();
        step();
        expectOutputs("rst_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            step();
            expectOutputs("post_rst.wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        step();
        expectOutputs("post_rst.flip", 4'b1011, 4'b1011, 4'b0000, 1'b1);
        step();
        expectOutputs("post_rst.after", 4'b1011, 4'b0000, 4'b0000, 1'b0);

        runTransition("clear2",   4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b1011);
        runTransition("bit2_on",  4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
